// File: rtl/pc_gen.sv
// Fetch address generator: issues one instruction fetch at a time, tracks the
// accepted PC, and merges trap/branch redirects that arrive between accepts.
module pc_gen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              IALIGN   = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            branch_addr_en,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            trap_en,
  input  logic            stall,
  input  logic            inst_ready,
  input  logic            inst_compressed,
  output logic [XLEN-1:0] curr_pc,
  output logic [XLEN-1:0] pc_add4,
  output logic [XLEN-1:0] next_pc,
  output logic            next_pc_en,
  output logic            inst_valid,
  output logic            misaligned
);

  typedef enum logic [1:0] {BOOT, WAIT, HOLD} state_t;

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(IALIGN - 1);

  state_t          state_q, state_d;
  logic            held_comp_q;
  logic            pend_valid_q, pend_trap_q;
  logic [XLEN-1:0] pend_addr_q;

  logic            accept, comp_eff, redirect, target_mis;
  logic [XLEN-1:0] inc, target, fetch_addr;

  always_comb begin
    accept     = 1'b0;
    comp_eff   = inst_compressed;
    inc        = XLEN'(4);
    redirect   = trap_en | branch_addr_en | pend_valid_q;
    target     = pend_addr_q;
    target_mis = 1'b0;
    fetch_addr = '0;
    state_d    = state_q;

    case (state_q)
      BOOT: state_d = WAIT;
      WAIT: begin
        accept = inst_ready & ~stall;
        if (inst_ready && stall) state_d = HOLD;
      end
      HOLD: begin
        accept   = ~stall;
        comp_eff = held_comp_q;
        if (!stall) state_d = WAIT;
      end
      default: state_d = BOOT;
    endcase

    if (IALIGN == 2 && comp_eff) inc = XLEN'(2);

    if (trap_en)             target = trap_addr;
    else if (branch_addr_en) target = branch_addr;

    target_mis = |(target & LOW_MASK);
    fetch_addr = redirect ? (target & ~LOW_MASK) : (next_pc + inc);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      curr_pc      <= RESET_PC;
      next_pc      <= RESET_PC;
      next_pc_en   <= 1'b0;
      inst_valid   <= 1'b0;
      misaligned   <= 1'b0;
      held_comp_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_trap_q  <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      next_pc_en <= (state_q == BOOT) | accept;
      inst_valid <= accept & ~redirect;
      misaligned <= accept & redirect & target_mis;

      if (state_q == WAIT && inst_ready && stall) held_comp_q <= inst_compressed;

      if (accept) begin
        curr_pc      <= next_pc;
        next_pc      <= fetch_addr;
        pend_valid_q <= 1'b0;
        pend_trap_q  <= 1'b0;
      end else if (trap_en) begin
        pend_valid_q <= 1'b1;
        pend_trap_q  <= 1'b1;
        pend_addr_q  <= trap_addr;
      end else if (branch_addr_en && !(pend_valid_q && pend_trap_q)) begin
        // a pending trap outranks any later branch
        pend_valid_q <= 1'b1;
        pend_trap_q  <= 1'b0;
        pend_addr_q  <= branch_addr;
      end
    end
  end

  assign pc_add4 = curr_pc + XLEN'(4);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: one IALIGN=4 and one IALIGN=2 instance,
// expected fetch pulses queued by the stimulus and checked by monitors.
module tb_pc_gen;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] cpc;
    logic        iv;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst4 = 1'b0, nrst2 = 1'b0;
  logic [31:0] branch_addr = '0, trap_addr = '0;
  logic        branch_addr_en = 1'b0, trap_en = 1'b0, stall = 1'b0;
  logic        inst_ready4 = 1'b0, inst_ready2 = 1'b0, inst_compressed = 1'b0;

  logic [31:0] curr_pc4, pc_add4_4, next_pc4, curr_pc2, pc_add4_2, next_pc2;
  logic        next_pc_en4, inst_valid4, misaligned4;
  logic        next_pc_en2, inst_valid2, misaligned2;

  int errors = 0;
  int checks = 0;
  exp_t q4[$];
  exp_t q2[$];

  pc_gen #(.XLEN(32), .RESET_PC(32'h0000_1000), .IALIGN(4)) dut4 (
    .clk(clk), .nrst(nrst4),
    .branch_addr(branch_addr), .branch_addr_en(branch_addr_en),
    .trap_addr(trap_addr), .trap_en(trap_en), .stall(stall),
    .inst_ready(inst_ready4), .inst_compressed(inst_compressed),
    .curr_pc(curr_pc4), .pc_add4(pc_add4_4), .next_pc(next_pc4),
    .next_pc_en(next_pc_en4), .inst_valid(inst_valid4), .misaligned(misaligned4)
  );

  pc_gen #(.XLEN(32), .RESET_PC(32'h0000_1000), .IALIGN(2)) dut2 (
    .clk(clk), .nrst(nrst2),
    .branch_addr(branch_addr), .branch_addr_en(branch_addr_en),
    .trap_addr(trap_addr), .trap_en(trap_en), .stall(stall),
    .inst_ready(inst_ready2), .inst_compressed(inst_compressed),
    .curr_pc(curr_pc2), .pc_add4(pc_add4_2), .next_pc(next_pc2),
    .next_pc_en(next_pc_en2), .inst_valid(inst_valid2), .misaligned(misaligned2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input logic [31:0] npc, input logic [31:0] cpc,
                      input logic iv, input logic mis);
    exp_t e;
    e = '{npc: npc, cpc: cpc, iv: iv, mis: mis};
    if (sel == 2) q2.push_back(e);
    else          q4.push_back(e);
  endtask

  // monitors: every fetch pulse must match the head of the queue
  always @(negedge clk) begin
    exp_t e;
    if (nrst4 && next_pc_en4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4 unexpected fetch: next_pc %h with empty queue", next_pc4);
      end else begin
        e = q4.pop_front();
        chk("dut4 next_pc", next_pc4, e.npc);
        chk("dut4 curr_pc", curr_pc4, e.cpc);
        chk("dut4 inst_valid", 32'(inst_valid4), 32'(e.iv));
        chk("dut4 misaligned", 32'(misaligned4), 32'(e.mis));
      end
    end else if (inst_valid4 || misaligned4) begin
      checks++; errors++;
      $display("FAIL dut4 stray pulse: inst_valid=%0b misaligned=%0b without fetch", inst_valid4, misaligned4);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (nrst2 && next_pc_en2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2 unexpected fetch: next_pc %h with empty queue", next_pc2);
      end else begin
        e = q2.pop_front();
        chk("dut2 next_pc", next_pc2, e.npc);
        chk("dut2 curr_pc", curr_pc2, e.cpc);
        chk("dut2 inst_valid", 32'(inst_valid2), 32'(e.iv));
        chk("dut2 misaligned", 32'(misaligned2), 32'(e.mis));
      end
    end else if (inst_valid2 || misaligned2) begin
      checks++; errors++;
      $display("FAIL dut2 stray pulse: inst_valid=%0b misaligned=%0b without fetch", inst_valid2, misaligned2);
    end
  end

  // waits for the fetch pulse, then returns one clock later at posedge+1
  task automatic wait_issue(input int sel);
    int n;
    n = 0;
    @(negedge clk);
    while (!((sel == 2) ? next_pc_en2 : next_pc_en4) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!((sel == 2) ? next_pc_en2 : next_pc_en4)) begin
      checks++; errors++;
      $display("FAIL issue_timeout dut%0d: next_pc_en stayed 0 for 20 cycles, expected 1", sel);
    end
    @(posedge clk);
    #1;
  endtask

  // drive one cycle of inputs, then return them to idle
  task automatic cyc(input int sel, input logic rdy, input logic comp, input logic stl,
                     input logic ben, input logic [31:0] ba,
                     input logic ten, input logic [31:0] ta);
    inst_ready4     = (sel == 2) ? 1'b0 : rdy;
    inst_ready2     = (sel == 2) ? rdy : 1'b0;
    inst_compressed = comp;
    stall           = stl;
    branch_addr_en  = ben;
    branch_addr     = ba;
    trap_en         = ten;
    trap_addr       = ta;
    @(posedge clk);
    #1;
    inst_ready4 = 1'b0; inst_ready2 = 1'b0; inst_compressed = 1'b0; stall = 1'b0;
    branch_addr_en = 1'b0; trap_en = 1'b0; branch_addr = '0; trap_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst curr_pc", curr_pc4, 32'h1000);
    chk("rst next_pc", next_pc4, 32'h1000);
    chk("rst next_pc_en", 32'(next_pc_en4), 32'h0);
    chk("rst inst_valid", 32'(inst_valid4), 32'h0);
    chk("rst misaligned", 32'(misaligned4), 32'h0);
    chk("rst pc_add4", pc_add4_4, 32'h1004);
    chk("rst dut2 curr_pc", curr_pc2, 32'h1000);

    // release with a stray inst_ready that must be ignored
    push(4, 32'h1000, 32'h1000, 1'b0, 1'b0);
    nrst4 = 1'b1;
    cyc(4, 1, 0, 0, 0, 0, 0, 0);

    push(4, 32'h1004, 32'h1000, 1'b1, 1'b0);
    wait_issue(4);
    cyc(4, 1, 0, 0, 0, 0, 0, 0);

    // 0x1004 returns under a three-cycle stall
    wait_issue(4);
    cyc(4, 1, 0, 1, 0, 0, 0, 0);
    cyc(4, 0, 0, 1, 0, 0, 0, 0);
    cyc(4, 0, 0, 1, 0, 0, 0, 0);
    chk("hold curr_pc", curr_pc4, 32'h1000);
    chk("hold next_pc", next_pc4, 32'h1004);
    chk("hold next_pc_en", 32'(next_pc_en4), 32'h0);
    push(4, 32'h1008, 32'h1004, 1'b1, 1'b0);
    cyc(4, 0, 0, 0, 0, 0, 0, 0);

    // branch while 0x1008 outstanding squashes it
    wait_issue(4);
    cyc(4, 0, 0, 0, 1, 32'h2000, 0, 0);
    push(4, 32'h2000, 32'h1008, 1'b0, 1'b0);
    cyc(4, 1, 0, 0, 0, 0, 0, 0);

    // simultaneous trap and branch: trap wins
    push(4, 32'h0100, 32'h2000, 1'b0, 1'b0);
    wait_issue(4);
    cyc(4, 1, 0, 0, 1, 32'h3000, 1, 32'h0100);

    // misaligned branch target
    push(4, 32'h2000, 32'h0100, 1'b0, 1'b1);
    wait_issue(4);
    cyc(4, 1, 0, 0, 1, 32'h2003, 0, 0);

    // pending trap survives a later branch
    push(4, 32'h0200, 32'h2000, 1'b0, 1'b0);
    wait_issue(4);
    cyc(4, 0, 0, 0, 0, 0, 1, 32'h0200);
    cyc(4, 0, 0, 0, 1, 32'h3000, 0, 0);
    cyc(4, 1, 0, 0, 0, 0, 0, 0);

    // trap replaces a pending branch
    push(4, 32'h0300, 32'h0200, 1'b0, 1'b0);
    wait_issue(4);
    cyc(4, 0, 0, 0, 1, 32'h4000, 0, 0);
    cyc(4, 0, 0, 0, 0, 0, 1, 32'h0300);
    cyc(4, 1, 1, 0, 0, 0, 0, 0);

    // compressed ignored at IALIGN=4
    push(4, 32'h0304, 32'h0300, 1'b1, 1'b0);
    wait_issue(4);
    cyc(4, 1, 1, 0, 0, 0, 0, 0);

    push(4, 32'h2000, 32'h0304, 1'b0, 1'b0);
    wait_issue(4);
    cyc(4, 1, 0, 0, 1, 32'h2000, 0, 0);

    // reset mid-request with a pending branch
    wait_issue(4);
    cyc(4, 0, 0, 0, 1, 32'h5000, 0, 0);
    nrst4 = 1'b0;
    #1;
    chk("midrst curr_pc", curr_pc4, 32'h1000);
    chk("midrst next_pc", next_pc4, 32'h1000);
    chk("midrst next_pc_en", 32'(next_pc_en4), 32'h0);
    chk("midrst pc_add4", pc_add4_4, 32'h1004);
    @(posedge clk);
    #1;
    push(4, 32'h1000, 32'h1000, 1'b0, 1'b0);
    nrst4 = 1'b1;
    push(4, 32'h1004, 32'h1000, 1'b1, 1'b0);
    wait_issue(4);
    cyc(4, 1, 0, 0, 0, 0, 0, 0);

    // address wrap
    push(4, 32'hFFFF_FFFC, 32'h1004, 1'b0, 1'b0);
    wait_issue(4);
    cyc(4, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    push(4, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0);
    wait_issue(4);
    cyc(4, 1, 0, 0, 0, 0, 0, 0);
    chk("wrap curr_pc", curr_pc4, 32'hFFFF_FFFC);
    chk("wrap pc_add4", pc_add4_4, 32'h0000_0000);
    @(negedge clk);
    @(posedge clk);
    #1;
    nrst4 = 1'b0;

    // IALIGN=2 instance
    push(2, 32'h1000, 32'h1000, 1'b0, 1'b0);
    nrst2 = 1'b1;
    push(2, 32'h1002, 32'h1000, 1'b1, 1'b0);
    wait_issue(2);
    cyc(2, 1, 1, 0, 0, 0, 0, 0);
    chk("c2 curr_pc", curr_pc2, 32'h1000);
    chk("c2 pc_add4", pc_add4_2, 32'h1004);

    push(2, 32'h1006, 32'h1002, 1'b1, 1'b0);
    wait_issue(2);
    cyc(2, 1, 0, 0, 0, 0, 0, 0);

    push(2, 32'h2002, 32'h1006, 1'b0, 1'b1);
    wait_issue(2);
    cyc(2, 1, 0, 0, 1, 32'h2003, 0, 0);

    // held compressed flag governs the increment after a stall
    push(2, 32'h2004, 32'h2002, 1'b1, 1'b0);
    wait_issue(2);
    cyc(2, 1, 1, 1, 0, 0, 0, 0);
    cyc(2, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("q4 drained", 32'(q4.size()), 32'h0);
    chk("q2 drained", 32'(q2.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
